// File: rtl/fifo_read_stream_adapter.sv
// ---------------------------------------------------------------------------
// fifo_read_stream_adapter
//
// Purpose:
//   Read-side consumer of the async FIFO, living in the read clock domain.
//   Converts the FIFO's empty / read_enable / read_data interface (memory
//   data returns one cycle after a pop) into a valid/ready stream. A small
//   in-order output buffer plus a one-bit in-flight flag let the block
//   sustain one word per cycle while never overflowing under back-pressure.
//
// Ports:
//   read_clock    in   1              read-domain clock, rising edge
//   read_reset    in   1              synchronous active-high reset
//   fifo_empty    in   1              registered empty flag from pointer ctrl
//   read_enable   out  1              pop request (combinational)
//   read_data     in   DATA_WIDTH     memory data, valid 1 cycle after a pop
//   out_valid     out  1              stream valid
//   out_ready     in   1              stream ready from downstream
//   out_data      out  DATA_WIDTH     stream data (head of buffer)
//   buffer_level  out  clog2(D)+1     words held in the buffer (no in-flight)
//   popped_count  out  32             stream handshake count (optional)
//
// Configuration:
//   READ_STREAM_STATS_EN  when defined, popped_count is a free-running 32-bit
//                         handshake counter; otherwise it is tied to zero and
//                         no counter flops exist.
//
// Note: read_enable depends combinationally on out_ready, so downstream must
// not derive out_ready combinationally from read_enable.
// ---------------------------------------------------------------------------
module fifo_read_stream_adapter #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic                          read_clock,
    input  logic                          read_reset,
    input  logic                          fifo_empty,
    output logic                          read_enable,
    input  logic [DATA_WIDTH-1:0]         read_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(BUFFER_DEPTH):0] buffer_level,
    output logic [31:0]                   popped_count
);

    localparam int LW = $clog2(BUFFER_DEPTH) + 1;
    localparam int IW = $clog2(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] r_buf [BUFFER_DEPTH];
    logic [LW-1:0]         r_level;
    logic                  r_inflight;
    logic [IW-1:0]         r_wr_idx;
    logic [IW-1:0]         r_rd_idx;

    logic                  w_pop;
    logic                  w_issue;
    logic [LW:0]           w_occupancy;
    logic [IW-1:0]         w_wr_idx_next;
    logic [IW-1:0]         w_rd_idx_next;

    // Handshake on the stream side.
    assign w_pop = out_valid & out_ready;

    // Occupancy after this cycle: buffered words plus the word already on its
    // way from memory, minus the one leaving now. One extra bit keeps the sum
    // free of wrap; it can never go negative because a pop needs level >= 1.
    assign w_occupancy = {1'b0, r_level} + (LW+1)'(r_inflight) - (LW+1)'(w_pop);

    // Issue only when a slot is guaranteed for the word one cycle from now.
    assign w_issue     = ~read_reset & ~fifo_empty
                       & (w_occupancy < (LW+1)'(BUFFER_DEPTH));
    assign read_enable = w_issue;

    // Circular index advance; explicit compare keeps non-power-of-two depths
    // correct.
    assign w_wr_idx_next = (r_wr_idx == IW'(BUFFER_DEPTH-1)) ? '0 : r_wr_idx + IW'(1);
    assign w_rd_idx_next = (r_rd_idx == IW'(BUFFER_DEPTH-1)) ? '0 : r_rd_idx + IW'(1);

    // Buffer, indices, level and in-flight tracking. A word returning from
    // memory is captured whenever the previous cycle issued a pop; reset
    // clears the in-flight flag so data arriving just after reset is dropped.
    always_ff @(posedge read_clock) begin
        if (read_reset) begin
            r_inflight <= 1'b0;
            r_level    <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= w_issue;
            r_level    <= w_occupancy[LW-1:0];
            if (r_inflight) begin
                r_buf[r_wr_idx] <= read_data;
                r_wr_idx        <= w_wr_idx_next;
            end
            if (w_pop) begin
                r_rd_idx <= w_rd_idx_next;
            end
        end
    end

    // Stream outputs come straight from registers.
    assign out_valid    = (r_level != '0);
    assign out_data     = r_buf[r_rd_idx];
    assign buffer_level = r_level;

`ifdef READ_STREAM_STATS_EN
    logic [31:0] r_popped_count;

    // Handshake counter; wraps naturally at 32 bits.
    always_ff @(posedge read_clock) begin
        if (read_reset) begin
            r_popped_count <= '0;
        end else if (w_pop) begin
            r_popped_count <= r_popped_count + 32'd1;
        end
    end

    assign popped_count = r_popped_count;
`else
    assign popped_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_stream_adapter
//
// Purpose:
//   Self-checking bench for fifo_read_stream_adapter. Models the pointer
//   controller and memory: a source queue supplies words, fifo_empty follows
//   the queue (optionally forced high), and a word appears on read_data one
//   cycle after each sampled read_enable. An expected-order queue checks
//   every stream handshake.
//
// Ports: none (top-level bench).
//
// Configuration:
//   READ_STREAM_STATS_EN  selects counter checks matching the DUT build.
// ---------------------------------------------------------------------------
module tb_fifo_read_stream_adapter;

    logic        read_clock = 1'b0;
    logic        read_reset;
    logic        fifo_empty;
    logic        read_enable;
    logic [7:0]  read_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  buffer_level;
    logic [31:0] popped_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] srcQ[$];
    logic [7:0] expQ[$];
    logic       forceEmpty;

    logic       sRe, sValid, sPop, sEmpty;
    logic [7:0] sData;
    logic [1:0] sLevel;
    int         popTotal = 0;
    int         reTotal  = 0;

    fifo_read_stream_adapter #(
        .DATA_WIDTH   (8),
        .BUFFER_DEPTH (2)
    ) dut (
        .read_clock   (read_clock),
        .read_reset   (read_reset),
        .fifo_empty   (fifo_empty),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .buffer_level (buffer_level),
        .popped_count (popped_count)
    );

    always #5 read_clock = ~read_clock;

    // Watchdog so a stuck run still terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Push a word into the modelled FIFO and the expected-order queue.
    task automatic loadWord(input logic [7:0] w);
        srcQ.push_back(w);
        expQ.push_back(w);
    endtask

    // One clock cycle: sample combinational/stream outputs with inputs
    // settled, check issue-while-empty and handshake order, advance the
    // clock, then model memory return and the registered empty flag.
    task automatic step();
        logic [7:0] expWord;
        #1;
        sRe    = read_enable;
        sValid = out_valid;
        sData  = out_data;
        sLevel = buffer_level;
        sEmpty = fifo_empty;
        sPop   = out_valid & out_ready;
        checks++;
        if (sRe === 1'b1 && sEmpty === 1'b1) begin
            errors++;
            $display("[TB] FAIL issue_while_empty: read_enable=%b fifo_empty=%b", sRe, sEmpty);
        end
        if (sPop === 1'b1) begin
            checks++;
            popTotal++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pop: got %h expected no word", sData);
            end else begin
                expWord = expQ.pop_front();
                if (sData !== expWord) begin
                    errors++;
                    $display("[TB] FAIL stream_order: got %h expected %h", sData, expWord);
                end
            end
        end
        if (sRe === 1'b1) reTotal++;
        @(posedge read_clock);
        #1;
        if (sRe === 1'b1 && srcQ.size() > 0) read_data = srcQ.pop_front();
        else read_data = 8'hEE;
        fifo_empty = forceEmpty || (srcQ.size() == 0);
    endtask

    // Bring the DUT to a clean idle state with empty model queues.
    task automatic doReset();
        read_reset = 1'b1;
        out_ready  = 1'b0;
        forceEmpty = 1'b1;
        fifo_empty = 1'b1;
        srcQ.delete();
        expQ.delete();
        step();
        step();
        read_reset = 1'b0;
    endtask

    // Reset values, and read_enable held low during reset even when the
    // FIFO reports data.
    task automatic test_reset();
        read_reset = 1'b1;
        out_ready  = 1'b1;
        forceEmpty = 1'b0;
        srcQ.delete();
        expQ.delete();
        srcQ.push_back(8'h5A);
        fifo_empty = 1'b0;
        read_data  = 8'h00;
        step();
        checks++;
        if (sRe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_read_enable: got %b expected 0", sRe);
        end
        step();
        checks++;
        if (buffer_level !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_level: got %0d expected 0", buffer_level);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 00", out_data);
        end
        checks++;
        if (popped_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %h expected 0", popped_count);
        end
        read_reset = 1'b0;
        forceEmpty = 1'b1;
        fifo_empty = 1'b1;
        srcQ.delete();
        expQ.delete();
        step();
    endtask

    // Four words streamed with out_ready high: issue in cycles 0-3, valid in
    // cycles 2-5, level settles at 1 while streaming.
    task automatic test_stream();
        logic [7:0] expRe    = 8'b0000_1111;
        logic [7:0] expValid = 8'b0011_1100;
        logic [7:0] expData [8] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
        logic [1:0] expLevel [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        doReset();
        loadWord(8'h11);
        loadWord(8'h22);
        loadWord(8'h33);
        loadWord(8'h44);
        forceEmpty = 1'b0;
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (sRe !== expRe[i]) begin
                errors++;
                $display("[TB] FAIL stream_re_c%0d: got %b expected %b", i, sRe, expRe[i]);
            end
            checks++;
            if (sValid !== expValid[i]) begin
                errors++;
                $display("[TB] FAIL stream_valid_c%0d: got %b expected %b", i, sValid, expValid[i]);
            end
            checks++;
            if (sLevel !== expLevel[i]) begin
                errors++;
                $display("[TB] FAIL stream_level_c%0d: got %0d expected %0d", i, sLevel, expLevel[i]);
            end
            if (expValid[i]) begin
                checks++;
                if (sData !== expData[i]) begin
                    errors++;
                    $display("[TB] FAIL stream_data_c%0d: got %h expected %h", i, sData, expData[i]);
                end
            end
`ifndef READ_STREAM_STATS_EN
            checks++;
            if (popped_count !== 32'd0) begin
                errors++;
                $display("[TB] FAIL stats_off_c%0d: got %h expected 0", i, popped_count);
            end
`endif
        end
        checks++;
`ifdef READ_STREAM_STATS_EN
        if (popped_count !== 32'd4) begin
            errors++;
            $display("[TB] FAIL stream_count: got %0d expected 4", popped_count);
        end
`else
        if (popped_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL stream_count: got %0d expected 0", popped_count);
        end
`endif
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL stream_drained: got %0d left expected 0", expQ.size());
        end
    endtask

    // Stalled downstream: exactly two pops fill the buffer, head word holds;
    // releasing out_ready re-enables issue in that same cycle.
    task automatic test_backpressure();
        int  rePulses = 0;
        bit  stable   = 1'b1;
        int  guard;
        doReset();
        for (int i = 0; i < 6; i++) loadWord(8'hA1 + 8'(i));
        forceEmpty = 1'b0;
        fifo_empty = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sRe === 1'b1) rePulses++;
            if (i >= 2 && (sValid !== 1'b1 || sData !== 8'hA1)) stable = 1'b0;
        end
        checks++;
        if (rePulses != 2) begin
            errors++;
            $display("[TB] FAIL bp_pulses: got %0d expected 2", rePulses);
        end
        checks++;
        if (buffer_level !== 2'd2) begin
            errors++;
            $display("[TB] FAIL bp_level: got %0d expected 2", buffer_level);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("[TB] FAIL bp_hold: head word not held at A1 (last %h valid %b)", sData, sValid);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (sRe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_resume: got %b expected 1", sRe);
        end
        guard = 0;
        while (expQ.size() != 0 && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %0d left expected 0", expQ.size());
        end
    endtask

    // One word: single issue, single-cycle valid two cycles later.
    task automatic test_single();
        logic [5:0] expRe    = 6'b00_0001;
        logic [5:0] expValid = 6'b00_0100;
        doReset();
        loadWord(8'h7C);
        forceEmpty = 1'b0;
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (sRe !== expRe[i]) begin
                errors++;
                $display("[TB] FAIL single_re_c%0d: got %b expected %b", i, sRe, expRe[i]);
            end
            checks++;
            if (sValid !== expValid[i]) begin
                errors++;
                $display("[TB] FAIL single_valid_c%0d: got %b expected %b", i, sValid, expValid[i]);
            end
        end
        checks++;
        if (buffer_level !== 2'd0) begin
            errors++;
            $display("[TB] FAIL single_level: got %0d expected 0", buffer_level);
        end
    endtask

    // Random ready and empty toggling over 1000 words; order and bound on
    // the level are checked every cycle.
    task automatic test_random();
        int pushed = 0;
        int startPops;
        int guard;
        doReset();
        startPops = popTotal;
        for (int c = 0; c < 20000 && (popTotal - startPops) < 1000; c++) begin
            if (pushed < 1000 && srcQ.size() < 3) begin
                loadWord(8'($urandom_range(0, 255)));
                pushed++;
            end
            out_ready  = 1'($urandom_range(0, 1));
            forceEmpty = ($urandom_range(0, 3) == 0);
            fifo_empty = forceEmpty || (srcQ.size() == 0);
            step();
            checks++;
            if ($isunknown(buffer_level) || buffer_level > 2'd2) begin
                errors++;
                $display("[TB] FAIL random_level: got %0d expected <= 2", buffer_level);
            end
        end
        out_ready  = 1'b1;
        forceEmpty = 1'b1;
        fifo_empty = 1'b1;
        guard = 0;
        while (expQ.size() != 0 && guard < 50) begin
            step();
            guard++;
        end
        checks++;
        if ((popTotal - startPops) != 1000) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d expected 1000", popTotal - startPops);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_loss: got %0d left expected 0", expQ.size());
        end
    endtask

    // Reset with a buffered word and one in flight: everything discarded,
    // and the word returning around reset is never presented.
    task automatic test_reset_mid();
        doReset();
        loadWord(8'hB1);
        loadWord(8'hB2);
        loadWord(8'hB3);
        loadWord(8'hB4);
        forceEmpty = 1'b0;
        fifo_empty = 1'b0;
        out_ready  = 1'b0;
        step();
        step();
        checks++;
        if (buffer_level !== 2'd1 || dut.r_inflight !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_setup: got level %0d inflight %b expected 1 and 1",
                     buffer_level, dut.r_inflight);
        end
        read_reset = 1'b1;
        step();
        checks++;
        if (sRe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_re: got %b expected 0", sRe);
        end
        checks++;
        if (out_valid !== 1'b0 || buffer_level !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_cleared: got valid %b level %0d expected 0 and 0",
                     out_valid, buffer_level);
        end
        read_reset = 1'b0;
        srcQ.delete();
        expQ.delete();
        forceEmpty = 1'b1;
        fifo_empty = 1'b1;
        out_ready  = 1'b1;
        read_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (sValid !== 1'b0 || sLevel !== 2'd0 || sRe !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_after_c%0d: got valid %b level %0d re %b expected 0 0 0",
                         i, sValid, sLevel, sRe);
            end
        end
    endtask

    // Counter wrap from a preloaded value near the top, or stays zero when
    // the counter is not built.
    task automatic test_stats();
        doReset();
        loadWord(8'hC1);
        loadWord(8'hC2);
        loadWord(8'hC3);
        forceEmpty = 1'b0;
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
`ifdef READ_STREAM_STATS_EN
        force dut.r_popped_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_popped_count;
        step();
        step();
        step();
        checks++;
        if (popped_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL stats_first: got %h expected FFFFFFFF", popped_count);
        end
        step();
        checks++;
        if (popped_count !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL stats_wrap: got %h expected 00000000", popped_count);
        end
        step();
        step();
        step();
        checks++;
        if (popped_count !== 32'h0000_0001) begin
            errors++;
            $display("[TB] FAIL stats_final: got %h expected 00000001", popped_count);
        end
`else
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (popped_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL stats_off: got %h expected 0", popped_count);
        end
`endif
    endtask

    // Scenario sequence.
    initial begin
        read_reset = 1'b1;
        fifo_empty = 1'b1;
        out_ready  = 1'b0;
        read_data  = 8'h00;
        forceEmpty = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_single();
        test_random();
        test_reset_mid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
